addsub_sseg_scan: RTL and testbench

Parametrised successor to the 4-bit adder/display block. Captures two WIDTH-bit operands on a load strobe and computes a registered add or subtract with carry and signed overflow. A prescaled scanner time-multiplexes operand A, operand B, the result and the carry flag across a row of common-anode 7-segment digits. Sits between the debounced switch inputs and the board's sseg/AN pins.

---
 rtl/addsub_sseg_scan.sv | 195 +++++++++++++++++++
 tb/tb_addsub_sseg_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sseg_scan.sv
// Registered WIDTH-bit add/subtract unit with carry and signed overflow, plus a
// prescaled common-anode 7-segment scanner showing A, B, the result and the carry.
module addsub_sseg_scan #(
    parameter  int WIDTH       = 8,
    parameter  int REFRESH_DIV = 50000,
    localparam int NIB         = WIDTH / 4,
    localparam int ND          = 3 * NIB + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             load,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             valid,
    output logic [7:0]       sseg,
    output logic [ND-1:0]    AN
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(ND);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } ctl_state_t;

    ctl_state_t       state, state_next;
    logic             compute_en;

    logic [WIDTH-1:0] op_a, op_b;
    logic             cin_q, sub_q;

    logic [WIDTH-1:0] b_eff;
    logic             carry_in_eff;
    logic [WIDTH:0]   sum_full;
    logic             ovf_calc;

    logic [PW-1:0]    prescale;
    logic             scan_on;
    logic             term_count;
    logic [IW-1:0]    digit_idx, digit_next;

    logic [3:0]       nib_val;
    logic             show_undef;
    logic [7:0]       glyph_next;

    function automatic logic [7:0] seg_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0: g = 8'h81;
            4'h1: g = 8'hF3;
            4'h2: g = 8'h49;
            4'h3: g = 8'h61;
            4'h4: g = 8'h33;
            4'h5: g = 8'h25;
            4'h6: g = 8'h05;
            4'h7: g = 8'hF1;
            4'h8: g = 8'h01;
            4'h9: g = 8'h31;
            4'hA: g = 8'h11;
            4'hB: g = 8'h07;
            4'hC: g = 8'h8D;
            4'hD: g = 8'h43;
            4'hE: g = 8'h0D;
            default: g = 8'h1D;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A held load keeps the unit pending; the result is only written once load drops.
    always_comb begin
        state_next = state;
        compute_en = 1'b0;
        if (load) begin
            state_next = ST_PENDING;
        end else if (state == ST_PENDING) begin
            compute_en = 1'b1;
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a  <= '0;
            op_b  <= '0;
            cin_q <= 1'b0;
            sub_q <= 1'b0;
        end else if (load) begin
            op_a  <= a;
            op_b  <= b;
            cin_q <= cin;
            sub_q <= sub;
        end
    end

    // Subtraction is A + ~B + 1, so cin only matters in add mode.
    always_comb begin
        b_eff        = sub_q ? ~op_b : op_b;
        carry_in_eff = sub_q ? 1'b1 : cin_q;
        sum_full     = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in_eff};
        ovf_calc     = (op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (sum_full[WIDTH-1] != op_a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
        end else if (load) begin
            valid  <= 1'b0;
        end else if (compute_en) begin
            result <= sum_full[WIDTH-1:0];
            cout   <= sum_full[WIDTH];
            ovf    <= ovf_calc;
            valid  <= 1'b1;
        end
    end

    // The first edge after reset only lights digit 0; counting starts on the next one,
    // so every digit, including digit 0, stays lit for exactly REFRESH_DIV cycles.
    always_comb begin
        term_count = scan_on && (prescale == PW'(REFRESH_DIV - 1));
        digit_next = digit_idx;
        if (term_count) begin
            if (digit_idx == IW'(ND - 1)) begin
                digit_next = '0;
            end else begin
                digit_next = digit_idx + {{(IW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale  <= '0;
            scan_on   <= 1'b0;
            digit_idx <= '0;
        end else begin
            scan_on   <= 1'b1;
            digit_idx <= digit_next;
            if (scan_on) begin
                prescale <= term_count ? '0 : prescale + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        nib_val    = 4'h0;
        show_undef = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            if (digit_next == IW'(i)) begin
                nib_val = op_a[i*4 +: 4];
            end
            if (digit_next == IW'(NIB + i)) begin
                nib_val = op_b[i*4 +: 4];
            end
            if (digit_next == IW'(2*NIB + i)) begin
                nib_val    = result[i*4 +: 4];
                show_undef = ~valid;
            end
        end
        if (digit_next == IW'(ND - 1)) begin
            nib_val    = {3'b000, cout};
            show_undef = ~valid;
        end
        glyph_next = show_undef ? 8'h13 : seg_glyph(nib_val);
    end

    // Anode and cathode patterns come from the same digit_next, so they always switch together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN   <= '1;
            sseg <= 8'hFF;
        end else begin
            AN   <= ~({{(ND-1){1'b0}}, 1'b1} << digit_next);
            sseg <= glyph_next;
        end
    end

endmodule

// File: tb/tb_addsub_sseg_scan.sv
// Scoreboard bench for addsub_sseg_scan: random loads against an arithmetic reference,
// plus a cycle-indexed model of the digit scan; a WIDTH=4, REFRESH_DIV=1 corner instance.
module tb_addsub_sseg_scan;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int NIB = 2;
    localparam int ND  = 7;
    localparam logic [7:0] GLYPH [16] = '{8'h81, 8'hF3, 8'h49, 8'h61, 8'h33, 8'h25, 8'h05, 8'hF1,
                                          8'h01, 8'h31, 8'h11, 8'h07, 8'h8D, 8'h43, 8'h0D, 8'h1D};

    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0, sub = 1'b0, load = 1'b0;
    logic [7:0] result;
    logic       cout, ovf, valid;
    logic [7:0] sseg;
    logic [6:0] an;

    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0, sub4 = 1'b0, load4 = 1'b0;
    logic [3:0] result4;
    logic       cout4, ovf4, valid4;
    logic [7:0] sseg4;
    logic [3:0] an4;

    int passCount  = 0;
    int checkCount = 0;

    exp_t q[$];
    exp_t q4[$];
    exp_t e;

    int         edgeCount;
    int         lastLoad;
    logic [7:0] capA, capB;
    logic       capCin, capSub;

    logic [7:0] snapA, snapB, snapRes;
    logic       snapValid, snapCout;
    logic       prevValid, prevValid4;
    logic       expValid;
    logic [6:0] expAn;
    logic [3:0] expAn4;
    logic [17:0] r;
    int         d;

    always #5 clk = ~clk;

    addsub_sseg_scan #(.WIDTH(W), .REFRESH_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin), .sub(sub), .load(load),
        .result(result), .cout(cout), .ovf(ovf), .valid(valid), .sseg(sseg), .AN(an)
    );

    addsub_sseg_scan #(.WIDTH(4), .REFRESH_DIV(1)) dut4 (
        .clk(clk), .reset(reset), .a(a4), .b(b4), .cin(cin4), .sub(sub4), .load(load4),
        .result(result4), .cout(cout4), .ovf(ovf4), .valid(valid4), .sseg(sseg4), .AN(an4)
    );

    // Reference arithmetic from signed/unsigned integer ranges: returns {ovf, cout, result}.
    function automatic logic [17:0] refAddSub(input int w, input int av, input int bv,
                                              input bit c, input bit s);
        int mask, bEff, total, sa, sb, sres;
        logic [17:0] o;
        mask  = (1 << w) - 1;
        bEff  = s ? (~bv & mask) : bv;
        total = av + bEff + (s ? 1 : int'(c));
        sa    = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb    = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        sres  = s ? sa - sb : sa + sb + int'(c);
        o        = '0;
        o[15:0]  = 16'(total & mask);
        o[16]    = ((total >> w) & 1) != 0;
        o[17]    = (sres > (1 << (w - 1)) - 1) || (sres < -(1 << (w - 1)));
        return o;
    endfunction

    function automatic logic [7:0] expSseg(input int dig);
        if (dig < NIB) return GLYPH[snapA[dig*4 +: 4]];
        if (dig < 2*NIB) return GLYPH[snapB[(dig-NIB)*4 +: 4]];
        if (!snapValid) return 8'h13;
        if (dig < 3*NIB) return GLYPH[snapRes[(dig-2*NIB)*4 +: 4]];
        return snapCout ? 8'hF3 : 8'h81;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic failCheck(input string name);
        checkCount++;
        $display("[TB] FAIL %s (t=%0t)", name, $time);
    endtask

    // Spec-level model: edges since reset, and when the operands were last captured.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edgeCount = 0;
            lastLoad  = -1;
            capA = '0; capB = '0; capCin = 1'b0; capSub = 1'b0;
        end else begin
            edgeCount++;
            if (load) begin
                lastLoad = edgeCount;
                capA = a; capB = b; capCin = cin; capSub = sub;
            end
        end
    end

    // Monitor: checks the scan every cycle and pops the scoreboard when valid rises.
    always @(negedge clk) begin
        if (!reset) begin
            snapA = '0; snapB = '0; snapRes = '0; snapValid = 1'b0; snapCout = 1'b0;
            prevValid = 1'b0; prevValid4 = 1'b0;
        end else if (edgeCount >= 1) begin
            expValid = (lastLoad >= 0) && (lastLoad < edgeCount);
            checkOutput("valid", 32'(valid), 32'(expValid));
            d = ((edgeCount - 1) / DIV) % ND;
            expAn = '1;
            expAn[d] = 1'b0;
            checkOutput("an", 32'(an), 32'(expAn));
            checkOutput("sseg", 32'(sseg), 32'(expSseg(d)));
            if (valid && !prevValid) begin
                if (q.size() == 0) begin
                    failCheck("unexpected valid");
                end else begin
                    e = q.pop_front();
                    checkOutput("result", 32'(result), 32'(e.res));
                    checkOutput("cout", 32'(cout), 32'(e.co));
                    checkOutput("ovf", 32'(ovf), 32'(e.ov));
                end
            end
            prevValid = valid;

            expAn4 = '1;
            expAn4[(edgeCount - 1) % 4] = 1'b0;
            checkOutput("an4", 32'(an4), 32'(expAn4));
            if (valid4 && !prevValid4) begin
                if (q4.size() == 0) begin
                    failCheck("unexpected valid4");
                end else begin
                    e = q4.pop_front();
                    checkOutput("result4", 32'(result4), 32'(e.res));
                    checkOutput("cout4", 32'(cout4), 32'(e.co));
                    checkOutput("ovf4", 32'(ovf4), 32'(e.ov));
                end
            end
            prevValid4 = valid4;

            snapA     = capA;
            snapB     = capB;
            snapValid = expValid;
            r         = refAddSub(W, int'(capA), int'(capB), capCin, capSub);
            snapRes   = r[7:0];
            snapCout  = r[16];
        end
    end

    // Holds load for 'hold' cycles (random A on all but the last), then idles.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input bit c,
                                 input bit s, input int hold, input int idle);
        logic [17:0] o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a    = (i == hold - 1) ? av : 8'($urandom);
            b    = bv;
            cin  = c;
            sub  = s;
            load = 1'b1;
        end
        o = refAddSub(W, int'(av), int'(bv), c, s);
        q.push_back('{res: o[7:0], co: o[16], ov: o[17]});
        @(negedge clk);
        load = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic applyStimulus4(input logic [3:0] av, input logic [3:0] bv, input bit c,
                                  input bit s);
        logic [17:0] o;
        @(negedge clk);
        a4 = av; b4 = bv; cin4 = c; sub4 = s; load4 = 1'b1;
        o = refAddSub(4, int'(av), int'(bv), c, s);
        q4.push_back('{res: o[7:0], co: o[16], ov: o[17]});
        @(negedge clk);
        load4 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;

        applyStimulus(8'hA7, 8'h5C, 1'b1, 1'b0, 1, 30);
        applyStimulus(8'h10, 8'h20, 1'b1, 1'b1, 1, 3);
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 1, 3);
        applyStimulus(8'h3C, 8'h21, 1'b0, 1'b0, 3, 3);
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1, 3);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        end

        applyStimulus(8'hE4, 8'h19, 1'b0, 1'b0, 1, 9);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("reset an", 32'(an), 32'(7'h7F));
        checkOutput("reset sseg", 32'(sseg), 32'(8'hFF));
        checkOutput("reset valid", 32'(valid), 32'(1'b0));
        checkOutput("reset result", 32'(result), 32'(8'h00));
        checkOutput("reset an4", 32'(an4), 32'(4'hF));
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release an", 32'(an), 32'(7'b1111110));
        checkOutput("release sseg", 32'(sseg), 32'(8'h81));

        applyStimulus4(4'hF, 4'h1, 1'b0, 1'b0);
        applyStimulus4(4'h8, 4'h1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end
        applyStimulus(8'h55, 8'hAA, 1'b1, 1'b0, 2, 2);

        for (int i = 0; i < 10 && (q.size() != 0 || q4.size() != 0); i++) begin
            @(negedge clk);
        end
        if (q.size() != 0 || q4.size() != 0) begin
            failCheck("results never became valid");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
